// File: rtl/sim_phase_ctrl_pkg.sv
// sim_phase_ctrl_pkg: shared phase type and widths
// for the run-phase sequencer.
package sim_phase_ctrl_pkg;

   localparam int PHASE_W = 3;

   typedef enum logic [PHASE_W-1:0] {
      PH_IDLE    = 3'd0,
      PH_DUV_RST = 3'd1,
      PH_RUN     = 3'd2,
      PH_DRAIN   = 3'd3,
      PH_DONE    = 3'd4
   } phase_e;

endpackage

// File: rtl/sim_phase_ctrl_obj.sv
// sim_phase_ctrl_obj: per-requester objection bank
// with raise/drop protocol checking.
module sim_phase_ctrl_obj #(
   parameter int NUM_REQ = 4
) (
   input  logic               clk_ip,
   input  logic               clear_ip,
   input  logic               enable_ip,
   input  logic [NUM_REQ-1:0] raise_ip,
   input  logic [NUM_REQ-1:0] drop_ip,
   output logic [NUM_REQ-1:0] objections_op,
   output logic               any_held_op,
   output logic               next_all_clear_op,
   output logic               acc_raise_op,
   output logic               error_op
);

   logic [NUM_REQ-1:0] obj_q;
   logic [NUM_REQ-1:0] obj_d;

   // Protocol check always; the bank only moves when enabled.
   always_comb begin
      obj_d        = obj_q;
      acc_raise_op = 1'b0;
      error_op     = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (raise_ip[i] && drop_ip[i]) begin
            error_op = 1'b1;
         end else if (raise_ip[i]) begin
            if (obj_q[i]) begin
               error_op = 1'b1;
            end else if (enable_ip) begin
               obj_d[i]     = 1'b1;
               acc_raise_op = 1'b1;
            end
         end else if (drop_ip[i]) begin
            if (!obj_q[i]) begin
               error_op = 1'b1;
            end else if (enable_ip) begin
               obj_d[i] = 1'b0;
            end
         end
      end
   end

   // Objection register, cleared with the block reset.
   always_ff @(posedge clk_ip) begin
      if (clear_ip) begin
         obj_q <= '0;
      end else begin
         obj_q <= obj_d;
      end
   end

   assign objections_op     = obj_q;
   assign any_held_op       = |obj_q;
   assign next_all_clear_op = (obj_d == '0);

endmodule

// File: rtl/sim_phase_ctrl.sv
// sim_phase_ctrl: DUV reset window, objection run phase,
// drain window and watchdog for the simulation top.
module sim_phase_ctrl
   import sim_phase_ctrl_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int CYC_W        = 32,
   parameter int RST_CYCLES   = 5,
   parameter int DRAIN_CYCLES = 16
) (
   input  logic               sim_phase_ctrl_clk_ip,
   input  logic               sim_phase_ctrl_rst_ip,
   input  logic               sim_phase_ctrl_start_ip,
   input  logic [NUM_REQ-1:0] sim_phase_ctrl_raise_ip,
   input  logic [NUM_REQ-1:0] sim_phase_ctrl_drop_ip,
   input  logic [CYC_W-1:0]   sim_phase_ctrl_timeout_ip,
   output logic               sim_phase_ctrl_duv_rst_op,
   output logic [PHASE_W-1:0] sim_phase_ctrl_phase_op,
   output logic [NUM_REQ-1:0] sim_phase_ctrl_objections_op,
   output logic [CYC_W-1:0]   sim_phase_ctrl_cycles_op,
   output logic               sim_phase_ctrl_finish_op,
   output logic               sim_phase_ctrl_timeout_op,
   output logic               sim_phase_ctrl_error_op
);

   localparam int RST_W = $clog2(RST_CYCLES + 1);
   localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);

   phase_e             phase_q;
   phase_e             phase_d;
   logic [RST_W-1:0]   rst_cnt_q;
   logic [RST_W-1:0]   rst_cnt_d;
   logic [DRN_W-1:0]   drn_cnt_q;
   logic [DRN_W-1:0]   drn_cnt_d;
   logic [CYC_W-1:0]   cycles_q;
   logic               duv_rst_q;
   logic               finish_q;
   logic               ever_q;
   logic               tmo_q;
   logic               err_q;
   logic               wd_fire;
   logic               wd_hit;
   logic               in_run;
   logic               pre_run;
   logic               err_now;
   logic               any_held;
   logic               next_clear;
   logic               acc_raise;
   logic               obj_err;

   assign in_run  = (phase_q == PH_RUN) || (phase_q == PH_DRAIN);
   assign pre_run = (phase_q == PH_IDLE) || (phase_q == PH_DUV_RST);
   assign wd_fire = (sim_phase_ctrl_timeout_ip != '0) &&
                    (cycles_q == sim_phase_ctrl_timeout_ip);
   assign err_now = pre_run ?
                    |(sim_phase_ctrl_raise_ip | sim_phase_ctrl_drop_ip) :
                    obj_err;

   sim_phase_ctrl_obj #(
      .NUM_REQ (NUM_REQ)
   ) u_obj (
      .clk_ip            (sim_phase_ctrl_clk_ip),
      .clear_ip          (sim_phase_ctrl_rst_ip),
      .enable_ip         (in_run),
      .raise_ip          (sim_phase_ctrl_raise_ip),
      .drop_ip           (sim_phase_ctrl_drop_ip),
      .objections_op     (sim_phase_ctrl_objections_op),
      .any_held_op       (any_held),
      .next_all_clear_op (next_clear),
      .acc_raise_op      (acc_raise),
      .error_op          (obj_err)
   );

   // Next phase and window counters; watchdog wins ties.
   always_comb begin
      phase_d   = phase_q;
      rst_cnt_d = rst_cnt_q;
      drn_cnt_d = drn_cnt_q;
      wd_hit    = 1'b0;
      unique case (phase_q)
         PH_IDLE: begin
            if (sim_phase_ctrl_start_ip) begin
               phase_d   = PH_DUV_RST;
               rst_cnt_d = RST_W'(RST_CYCLES - 1);
            end
         end
         PH_DUV_RST: begin
            if (rst_cnt_q == '0) begin
               phase_d = PH_RUN;
            end else begin
               rst_cnt_d = rst_cnt_q - 1'b1;
            end
         end
         PH_RUN: begin
            if (wd_fire) begin
               phase_d = PH_DONE;
               wd_hit  = 1'b1;
            end else if (ever_q && next_clear) begin
               phase_d   = PH_DRAIN;
               drn_cnt_d = DRN_W'(DRAIN_CYCLES - 1);
            end
         end
         PH_DRAIN: begin
            if (wd_fire) begin
               phase_d = PH_DONE;
               wd_hit  = 1'b1;
            end else if (acc_raise || any_held) begin
               phase_d = PH_RUN;
            end else if (drn_cnt_q == '0) begin
               phase_d = PH_DONE;
            end else begin
               drn_cnt_d = drn_cnt_q - 1'b1;
            end
         end
         PH_DONE: begin
            phase_d = PH_DONE;
         end
         default: begin
            phase_d = PH_IDLE;
         end
      endcase
   end

   // Phase, counters, registered outputs and sticky flags.
   always_ff @(posedge sim_phase_ctrl_clk_ip) begin
      if (sim_phase_ctrl_rst_ip) begin
         phase_q   <= PH_IDLE;
         rst_cnt_q <= '0;
         drn_cnt_q <= '0;
         cycles_q  <= '0;
         duv_rst_q <= 1'b1;
         finish_q  <= 1'b0;
         ever_q    <= 1'b0;
         tmo_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         phase_q   <= phase_d;
         rst_cnt_q <= rst_cnt_d;
         drn_cnt_q <= drn_cnt_d;
         duv_rst_q <= (phase_d == PH_IDLE) ||
                      (phase_d == PH_DUV_RST);
         finish_q  <= (phase_d == PH_DONE);
         if (phase_q == PH_DUV_RST) begin
            cycles_q <= '0;
         end else if (in_run && (cycles_q != '1)) begin
            cycles_q <= cycles_q + CYC_W'(1);
         end
         ever_q <= ever_q | acc_raise;
         tmo_q  <= tmo_q | wd_hit;
         err_q  <= err_q | err_now;
      end
   end

   assign sim_phase_ctrl_phase_op   = phase_q;
   assign sim_phase_ctrl_duv_rst_op = duv_rst_q;
   assign sim_phase_ctrl_cycles_op  = cycles_q;
   assign sim_phase_ctrl_finish_op  = finish_q;
   assign sim_phase_ctrl_timeout_op = tmo_q;
   assign sim_phase_ctrl_error_op   = err_q;

endmodule
